fifo_flex: RTL and testbench
============================

FIFO_FLEX -- requirements
Module: fifo_flex

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter AWIDTH, default 2: address width; depth DEPTH = 2**AWIDTH words.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1: almost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 1: almost_empty asserts when count <= AE_LEVEL.
REQ-005 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port clear  input  1: synchronous flush; discards contents and clears error flags.
REQ-008 SHALL have port wr  input  1: write request.
REQ-009 SHALL have port w_data  input  DWIDTH: write data.
REQ-010 SHALL have port rd  input  1: read request; pops the head word.
REQ-011 SHALL have port r_data  output  DWIDTH: head word (show-ahead), valid whenever empty=0.
REQ-012 SHALL have port empty  output  1: no words stored.
REQ-013 SHALL have port full  output  1: DEPTH words stored.
REQ-014 SHALL have port almost_empty  output  1: count <= AE_LEVEL.
REQ-015 SHALL have port almost_full  output  1: count >= AF_LEVEL.
REQ-016 SHALL have port count  output  AWIDTH+1: current occupancy, 0..DEPTH.
REQ-017 SHALL have port overflow  output  1: sticky; a write was refused.
REQ-018 SHALL have port underflow  output  1: sticky; a read was refused.

Function
REQ-019 SHALL hold storage in a DEPTH x DWIDTH array, written at w_ptr, read at r_ptr; pointers AWIDTH bits, wrapping DEPTH-1 -> 0 by natural overflow.
REQ-020 SHALL drive r_data combinationally from array[r_ptr]; value when empty=1 is don't-care.
REQ-021 SHALL accept a write (w_acc) when wr=1 and (full=0 or rd=1); w_data stored at w_ptr on that edge, w_ptr increments.
REQ-022 SHALL accept a read (r_acc) when rd=1 and empty=0; r_ptr increments on that edge.
REQ-023 SHALL, when full and wr=rd=1, perform both read and write; count stays DEPTH, full stays 1 (pass-through at full).
REQ-024 SHALL, when empty and wr=rd=1, perform the write only; rd ignored, underflow set, count becomes 1.
REQ-025 SHALL update count: +1 on w_acc only, -1 on r_acc only, unchanged on both or neither.
REQ-026 SHALL register empty, full, almost_empty, almost_full from next-state count, so all flags match count in the same cycle.
REQ-027 SHALL set overflow when wr=1 and w_acc=0; set underflow when rd=1 and r_acc=0; each stays 1 until reset or clear.
REQ-028 SHALL, on clear=1 (reset=0), zero pointers and count, set empty=1, full=0, clear overflow/underflow; wr and rd in that cycle are ignored.
REQ-029 SHALL have zero-cycle write-to-read latency of flags: a word written at edge N gives empty=0 and valid r_data after edge N.

Reset
REQ-030 SHALL, while reset=1 at a clk edge, set w_ptr=0, r_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0 (AF_LEVEL>0), overflow=0, underflow=0; reset has priority over clear, wr, rd.
REQ-031 SHALL not reset the storage array; contents are unreachable until rewritten.
REQ-032 SHALL, on reset mid-operation, discard all stored words; first read after release returns first word written after release.

Verification (DWIDTH=8, AWIDTH=2, AF_LEVEL=3, AE_LEVEL=1)
REQ-033 SHALL cover fill: write 0x11,0x22,0x33,0x44 on 4 cycles -> count 1,2,3,4; almost_empty drops after 2nd; almost_full at 3rd; full at 4th; r_data=0x11.
REQ-034 SHALL cover overflow: 5th write 0x55 while full, rd=0 -> count stays 4, overflow=1, drained order 0x11,0x22,0x33,0x44.
REQ-035 SHALL cover full pass-through: full, wr=rd=1 with 0x66 -> 0x11 popped, count 4, full=1; later drain ends with 0x66.
REQ-036 SHALL cover empty rd+wr: empty, wr=rd=1 with 0xA5 -> count 1, underflow=1, r_data=0xA5.
REQ-037 SHALL cover wrap-around: 10 interleaved writes/reads of 0x00..0x09 keeping count<=2 -> data order preserved across pointer wrap, no error flags.
REQ-038 SHALL cover clear and reset mid-stream: count=3 with flags set, clear=1 -> next cycle count 0, empty=1, overflow=underflow=0; same with reset=1 and wr=1 -> write ignored.

Source files
------------

// File: rtl/fifo_flex.sv
// -----------------------------------------------------------------------------
// fifo_flex -- single-clock show-ahead FIFO with occupancy count, programmable
// almost-full / almost-empty thresholds and sticky overflow / underflow flags.
//
// Parameters
//   DWIDTH    data word width
//   AWIDTH    address width, DEPTH = 2**AWIDTH
//   AF_LEVEL  almost_full  asserts when count >= AF_LEVEL
//   AE_LEVEL  almost_empty asserts when count <= AE_LEVEL
//
// Ports
//   clk           clock, all state changes on the rising edge
//   reset         synchronous active-high reset (highest priority)
//   clear         synchronous flush of contents and error flags
//   wr / w_data   write request and data
//   rd            read request, pops the head word
//   r_data        head word, valid whenever empty = 0
//   empty, full, almost_empty, almost_full   registered status flags
//   count         occupancy 0..DEPTH
//   overflow      sticky: a write was refused
//   underflow     sticky: a read was refused
// -----------------------------------------------------------------------------
module fifo_flex #(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 2,
  parameter int AF_LEVEL = (2**AWIDTH) - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr,
  input  logic [DWIDTH-1:0] w_data,
  input  logic              rd,
  output logic [DWIDTH-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [AWIDTH:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH   = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_C = DEPTH[AWIDTH:0];
  localparam logic [AWIDTH:0] AF_C    = AF_LEVEL[AWIDTH:0];
  localparam logic [AWIDTH:0] AE_C    = AE_LEVEL[AWIDTH:0];
  // Threshold flag values for an empty FIFO (count = 0).
  localparam logic            AE_RST  = (AE_LEVEL >= 0);
  localparam logic            AF_RST  = (AF_LEVEL <= 0);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [AWIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [AWIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ae_q, ae_d;
  logic              af_q, af_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              w_acc, r_acc;

  // A write is taken while full only if a read frees the slot in the same
  // edge (pass-through). A read on empty is always refused, even with a
  // simultaneous write, because the head word does not exist yet.
  always_comb begin
    w_acc   = wr & (~full_q | rd);
    r_acc   = rd & ~empty_q;

    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q | (wr & ~w_acc);
    unf_d   = unf_q | (rd & ~r_acc);

    if (w_acc) w_ptr_d = w_ptr_q + AWIDTH'(1);
    if (r_acc) r_ptr_d = r_ptr_q + AWIDTH'(1);

    case ({w_acc, r_acc})
      2'b10:   count_d = count_q + (AWIDTH+1)'(1);
      2'b01:   count_d = count_q - (AWIDTH+1)'(1);
      default: count_d = count_q;
    endcase

    // Flush overrides any request seen in the same cycle.
    if (clear) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end

    // Flags derive from the next count so they line up with count itself.
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
    ae_d    = (count_d <= AE_C);
    af_d    = (count_d >= AF_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= AE_RST;
      af_q    <= AF_RST;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage has no reset; stale words are unreachable once pointers are zeroed.
  always_ff @(posedge clk) begin
    if (w_acc && !reset && !clear) mem_q[w_ptr_q] <= w_data;
  end

  assign r_data       = mem_q[r_ptr_q];
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_flex.sv
module tb_fifo_flex;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       wr;
  logic [7:0] w_data;
  logic       rd;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  fifo_flex #(
    .DWIDTH  (8),
    .AWIDTH  (2),
    .AF_LEVEL(3),
    .AE_LEVEL(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .wr          (wr),
    .w_data      (w_data),
    .rd          (rd),
    .r_data      (r_data),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given requests; outputs are stable 1 time unit later.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wr = w; w_data = d; rd = r;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(1'b1, 8'hEE, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", empty); end
    total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL rst_ae got=%b exp=1", almost_empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", full); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL rst_af got=%b exp=0", almost_full); end
    total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b%b exp=00", overflow, underflow); end
  endtask

  task automatic test_fill;
    step(1'b1, 8'h11, 1'b0);
    total++; if ({count, empty, almost_empty, almost_full, full} !== {3'd1, 4'b0100}) begin bad++; $display("FAIL fill1 got cnt=%0d e=%b ae=%b af=%b f=%b exp cnt=1 e=0 ae=1 af=0 f=0", count, empty, almost_empty, almost_full, full); end
    total++; if (r_data !== 8'h11) begin bad++; $display("FAIL fill1_rdata got=%h exp=11", r_data); end
    step(1'b1, 8'h22, 1'b0);
    total++; if ({count, empty, almost_empty, almost_full, full} !== {3'd2, 4'b0000}) begin bad++; $display("FAIL fill2 got cnt=%0d e=%b ae=%b af=%b f=%b exp cnt=2 e=0 ae=0 af=0 f=0", count, empty, almost_empty, almost_full, full); end
    step(1'b1, 8'h33, 1'b0);
    total++; if ({count, empty, almost_empty, almost_full, full} !== {3'd3, 4'b0010}) begin bad++; $display("FAIL fill3 got cnt=%0d e=%b ae=%b af=%b f=%b exp cnt=3 e=0 ae=0 af=1 f=0", count, empty, almost_empty, almost_full, full); end
    step(1'b1, 8'h44, 1'b0);
    total++; if ({count, empty, almost_empty, almost_full, full} !== {3'd4, 4'b0011}) begin bad++; $display("FAIL fill4 got cnt=%0d e=%b ae=%b af=%b f=%b exp cnt=4 e=0 ae=0 af=1 f=1", count, empty, almost_empty, almost_full, full); end
    total++; if (r_data !== 8'h11) begin bad++; $display("FAIL fill4_rdata got=%h exp=11", r_data); end
  endtask

  task automatic test_overflow;
    logic [7:0] exp_q [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    step(1'b1, 8'h55, 1'b0);
    total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    for (int i = 0; i < 4; i++) begin
      total++; if (r_data !== exp_q[i]) begin bad++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, r_data, exp_q[i]); end
      step(1'b0, 8'h00, 1'b1);
    end
    total++; if ({count, empty, underflow} !== {3'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL ovf_end got cnt=%0d e=%b u=%b exp cnt=0 e=1 u=0", count, empty, underflow); end
  endtask

  task automatic test_passthrough;
    logic [7:0] exp_q [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    step(1'b1, 8'h66, 1'b1);
    total++; if ({count, full} !== {3'd4, 1'b1}) begin bad++; $display("FAIL pass_state got cnt=%0d f=%b exp cnt=4 f=1", count, full); end
    for (int i = 0; i < 4; i++) begin
      total++; if (r_data !== exp_q[i]) begin bad++; $display("FAIL pass_drain%0d got=%h exp=%h", i, r_data, exp_q[i]); end
      step(1'b0, 8'h00, 1'b1);
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL pass_empty got=%b exp=1", empty); end
  endtask

  task automatic test_empty_rdwr;
    step(1'b1, 8'hA5, 1'b1);
    total++; if (count !== 3'd1) begin bad++; $display("FAIL erw_count got=%0d exp=1", count); end
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL erw_unf got=%b exp=1", underflow); end
    total++; if ({empty, r_data} !== {1'b0, 8'hA5}) begin bad++; $display("FAIL erw_data got e=%b d=%h exp e=0 d=a5", empty, r_data); end
    step(1'b0, 8'h00, 1'b1);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL erw_pop got=%b exp=1", empty); end
  endtask

  task automatic test_wrap;
    clear = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    clear = 1'b0;
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    for (int i = 2; i < 10; i++) begin
      total++; if (r_data !== 8'(i - 2)) begin bad++; $display("FAIL wrap_head%0d got=%h exp=%h", i, r_data, 8'(i - 2)); end
      step(1'b1, 8'(i), 1'b1);
    end
    total++; if (count !== 3'd2) begin bad++; $display("FAIL wrap_count got=%0d exp=2", count); end
    total++; if (r_data !== 8'h08) begin bad++; $display("FAIL wrap_tail8 got=%h exp=08", r_data); end
    step(1'b0, 8'h00, 1'b1);
    total++; if (r_data !== 8'h09) begin bad++; $display("FAIL wrap_tail9 got=%h exp=09", r_data); end
    step(1'b0, 8'h00, 1'b1);
    total++; if ({empty, overflow, underflow} !== 3'b100) begin bad++; $display("FAIL wrap_flags got e=%b o=%b u=%b exp e=1 o=0 u=0", empty, overflow, underflow); end
  endtask

  // Leaves count=3 with both sticky flags set.
  task automatic load_three_with_errors;
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'hC4, 1'b0);
    step(1'b1, 8'hC5, 1'b0);
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_clear_reset;
    load_three_with_errors();
    total++; if ({count, overflow, underflow} !== {3'd3, 2'b11}) begin bad++; $display("FAIL clr_pre got cnt=%0d o=%b u=%b exp cnt=3 o=1 u=1", count, overflow, underflow); end
    clear = 1'b1;
    step(1'b1, 8'hEE, 1'b0);
    clear = 1'b0;
    total++; if ({count, empty, full, overflow, underflow} !== {3'd0, 4'b1000}) begin bad++; $display("FAIL clr_post got cnt=%0d e=%b f=%b o=%b u=%b exp cnt=0 e=1 f=0 o=0 u=0", count, empty, full, overflow, underflow); end
    load_three_with_errors();
    reset = 1'b1;
    step(1'b1, 8'hEE, 1'b0);
    reset = 1'b0;
    total++; if ({count, empty, almost_empty, almost_full, full, overflow, underflow} !== {3'd0, 6'b110000}) begin bad++; $display("FAIL rstmid_post got cnt=%0d e=%b ae=%b af=%b f=%b o=%b u=%b exp cnt=0 e=1 ae=1 others 0", count, empty, almost_empty, almost_full, full, overflow, underflow); end
    step(1'b1, 8'h77, 1'b0);
    total++; if ({count, r_data} !== {3'd1, 8'h77}) begin bad++; $display("FAIL rstmid_first got cnt=%0d d=%h exp cnt=1 d=77", count, r_data); end
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_passthrough();
    test_empty_rdwr();
    test_wrap();
    test_clear_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
